// File: rtl/irq_arbiter.sv
// Priority arbiter sharing one irq/icause/iack path among NSRC edge-captured, maskable sources.
// Define IRQ_ARB_ROUND_ROBIN_EN for round-robin selection; default build is fixed priority (lowest index).
module irq_arbiter #(
   parameter int NSRC       = 4,
   parameter int CAUSE_BASE = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] irq_src,
   output logic            irq,
   output logic [3:0]      icause,
   input  logic            iack,
   input  logic [31:0]     a,
   input  logic [31:0]     d,
   input  logic            we,
   output logic [31:0]     spo
);

   localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
   localparam logic [3:0] CB = 4'(CAUSE_BASE);

   localparam logic [7:0] OFS_PENDING = 8'h00;
   localparam logic [7:0] OFS_MASK    = 8'h04;
   localparam logic [7:0] OFS_ACTIVE  = 8'h08;
   localparam logic [7:0] OFS_SWTRIG  = 8'h0C;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ASSERT = 2'd1,
      ST_GAP    = 2'd2
   } state_t;

   state_t state, state_d;

   logic [NSRC-1:0] src_q;
   logic [NSRC-1:0] pending, pending_d;
   logic [NSRC-1:0] mask, mask_d;
   logic [NSRC-1:0] edge_set, sw_set, w1c, ack_clr, eligible;
   logic [IW-1:0]   idx, idx_d, winner;
   logic            win_valid;
   logic            wr_pend, wr_mask, wr_swtrig;
   logic            ack_now;

`ifdef IRQ_ARB_ROUND_ROBIN_EN
   logic [IW-1:0]   rr_ptr;
`endif

   logic unused_bits;
   assign unused_bits = ^{a[31:8], d[31:NSRC]};

   assign wr_pend   = we && (a[7:0] == OFS_PENDING);
   assign wr_mask   = we && (a[7:0] == OFS_MASK);
   assign wr_swtrig = we && (a[7:0] == OFS_SWTRIG);
   assign ack_now   = (state == ST_ASSERT) && iack;

   // Set sources take precedence over clears so a coincident event is never lost.
   always_comb begin
      edge_set = irq_src & ~src_q;
      sw_set   = wr_swtrig ? d[NSRC-1:0] : '0;
      w1c      = wr_pend ? d[NSRC-1:0] : '0;
      ack_clr  = '0;
      if (ack_now) ack_clr[idx] = 1'b1;
      pending_d = (pending & ~(w1c | ack_clr)) | edge_set | sw_set;
      mask_d    = wr_mask ? d[NSRC-1:0] : mask;
   end

   assign eligible = pending & ~mask;

   always_comb begin
      winner    = '0;
      win_valid = 1'b0;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
      for (int k = 1; k <= NSRC; k++) begin
         if (!win_valid && eligible[(int'(rr_ptr) + k) % NSRC]) begin
            winner    = IW'((int'(rr_ptr) + k) % NSRC);
            win_valid = 1'b1;
         end
      end
`else
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            winner    = IW'(i);
            win_valid = 1'b1;
         end
      end
`endif
   end

   // A grant is withdrawn as soon as its pending bit is cleared or its mask set, without a gap.
   always_comb begin
      state_d = state;
      idx_d   = idx;
      case (state)
         ST_IDLE: begin
            if (win_valid) begin
               state_d = ST_ASSERT;
               idx_d   = winner;
            end
         end
         ST_ASSERT: begin
            if (iack) begin
               state_d = ST_GAP;
            end else if (!pending_d[idx] || mask_d[idx]) begin
               state_d = ST_IDLE;
            end
         end
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         idx     <= '0;
         src_q   <= '0;
         pending <= '0;
         mask    <= '1;
      end else begin
         state   <= state_d;
         idx     <= idx_d;
         src_q   <= irq_src;
         pending <= pending_d;
         mask    <= mask_d;
      end
   end

`ifdef IRQ_ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= IW'(NSRC - 1);
      end else if (ack_now) begin
         rr_ptr <= idx;
      end
   end
`endif

   assign irq    = (state == ST_ASSERT);
   assign icause = irq ? (CB + 4'(idx)) : 4'd0;

   always_comb begin
      spo = '0;
      case (a[7:0])
         OFS_PENDING: spo[NSRC-1:0] = pending;
         OFS_MASK:    spo[NSRC-1:0] = mask;
         OFS_ACTIVE: begin
            spo[31]     = irq;
            spo[IW-1:0] = irq ? idx : '0;
         end
         default: spo = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: grant causes go through an expected queue, registers checked inline.
// Builds with or without IRQ_ARB_ROUND_ROBIN_EN; only the grant order in the two-source case differs.
module tb_irq_arbiter;

   localparam int NSRC = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [NSRC-1:0] irq_src;
   logic            irq;
   logic [3:0]      icause;
   logic            iack;
   logic [31:0]     a;
   logic [31:0]     d;
   logic            we;
   logic [31:0]     spo;

   logic [3:0] exp_q[$];
   int tests_run    = 0;
   int tests_failed = 0;

   irq_arbiter #(.NSRC(NSRC), .CAUSE_BASE(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .irq_src (irq_src),
      .irq     (irq),
      .icause  (icause),
      .iack    (iack),
      .a       (a),
      .d       (d),
      .we      (we),
      .spo     (spo)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
      a  = {24'h0, addr};
      d  = data;
      we = 1'b1;
      step();
      we = 1'b0;
      a  = '0;
      d  = '0;
   endtask

   task automatic check_reg(input string tag, input logic [7:0] addr, input logic [31:0] exp);
      logic [31:0] v;
      a = {24'h0, addr};
      #1;
      v = spo;
      check(tag, v, exp);
   endtask

   task automatic do_ack();
      iack = 1'b1;
      step();
      iack = 1'b0;
   endtask

   // Wait for irq, then compare icause against the oldest queued expectation.
   task automatic expect_grant(input string tag);
      int n;
      logic [3:0] e;
      n = 0;
      while (irq !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check({tag, "_irq"}, {31'h0, irq}, 32'h1);
      if (exp_q.size() == 0) begin
         tests_run++;
         tests_failed++;
         $error("FAIL %s_queue: observed grant icause %0h expected no grant", tag, icause);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_icause"}, {28'h0, icause}, {28'h0, e});
      end
   endtask

   initial begin
      rst     = 1'b1;
      irq_src = '0;
      iack    = 1'b0;
      a       = '0;
      d       = '0;
      we      = 1'b0;
      repeat (3) step();
      rst = 1'b0;

      // Reset state
      check("rst_irq", {31'h0, irq}, 32'h0);
      check("rst_icause", {28'h0, icause}, 32'h0);
      check_reg("rst_pending", 8'h00, 32'h0);
      check_reg("rst_mask", 8'h04, 32'hF);
      check_reg("rst_active", 8'h08, 32'h0);

      // Single source: two-cycle latency, ack, then deassert
      bus_write(8'h04, 32'h0);
      exp_q.push_back(4'd8);
      irq_src[0] = 1'b1;
      step();
      check("t1_lat1_irq", {31'h0, irq}, 32'h0);
      check_reg("t1_lat1_pending", 8'h00, 32'h1);
      step();
      check("t1_lat2_irq", {31'h0, irq}, 32'h1);
      expect_grant("t1_grant");
      check_reg("t1_active", 8'h08, 32'h8000_0000);
      do_ack();
      check("t1_ack_irq", {31'h0, irq}, 32'h0);
      check("t1_ack_icause", {28'h0, icause}, 32'h0);
      check_reg("t1_ack_pending", 8'h00, 32'h0);
      step();
      check("t1_gap_irq", {31'h0, irq}, 32'h0);
      irq_src = '0;
      step();

      // Masked source stays pending until unmasked
      bus_write(8'h04, 32'h2);
      exp_q.push_back(4'd8);
      irq_src = 4'b0011;
      expect_grant("t2_src0");
      do_ack();
      check_reg("t2_pending", 8'h00, 32'h2);
      step();
      step();
      check("t2_masked_irq", {31'h0, irq}, 32'h0);
      exp_q.push_back(4'd9);
      bus_write(8'h04, 32'h0);
      expect_grant("t2_src1");
      do_ack();
      irq_src = '0;
      step();
      step();

      // Two sources at once: order depends on build
`ifdef IRQ_ARB_ROUND_ROBIN_EN
      exp_q.push_back(4'd11);
      exp_q.push_back(4'd9);
`else
      exp_q.push_back(4'd9);
      exp_q.push_back(4'd11);
`endif
      irq_src = 4'b1010;
      expect_grant("t3_first");
      do_ack();
      expect_grant("t3_second");
      do_ack();
      irq_src = '0;
      step();
      step();

      // Withdrawal by W1C: drops next cycle, no gap before the next grant
      exp_q.push_back(4'd10);
      irq_src = 4'b0100;
      expect_grant("t4_src2");
      bus_write(8'h0C, 32'h2);
      check("t4_hold_irq", {31'h0, irq}, 32'h1);
      check("t4_hold_icause", {28'h0, icause}, 32'hA);
      bus_write(8'h00, 32'h4);
      check("t4_w1c_irq", {31'h0, irq}, 32'h0);
      check_reg("t4_w1c_active", 8'h08, 32'h0);
      check_reg("t4_w1c_pending", 8'h00, 32'h2);
      exp_q.push_back(4'd9);
      step();
      check("t4_nogap_irq", {31'h0, irq}, 32'h1);
      expect_grant("t4_sw_src1");
      do_ack();
      irq_src = '0;
      step();

      // Withdrawal by mask keeps the pending bit
      exp_q.push_back(4'd11);
      bus_write(8'h0C, 32'h8);
      expect_grant("t4b_src3");
      bus_write(8'h04, 32'h8);
      check("t4b_mask_irq", {31'h0, irq}, 32'h0);
      check_reg("t4b_mask_pending", 8'h00, 32'h8);
      step();
      step();
      check("t4b_masked_irq", {31'h0, irq}, 32'h0);
      exp_q.push_back(4'd11);
      bus_write(8'h04, 32'h0);
      expect_grant("t4b_regrant");
      do_ack();
      step();

      // iack coincident with a fresh edge on the granted source
      exp_q.push_back(4'd8);
      irq_src[0] = 1'b1;
      expect_grant("t5_first");
      irq_src[0] = 1'b0;
      step();
      check("t5_hold_irq", {31'h0, irq}, 32'h1);
      irq_src[0] = 1'b1;
      iack = 1'b1;
      step();
      iack = 1'b0;
      check("t5_ack_irq", {31'h0, irq}, 32'h0);
      check_reg("t5_ack_pending", 8'h00, 32'h1);
      step();
      check("t5_gap_irq", {31'h0, irq}, 32'h0);
      exp_q.push_back(4'd8);
      step();
      check("t5_regrant_irq", {31'h0, irq}, 32'h1);
      expect_grant("t5_regrant");

      // Reset during an active grant
      rst = 1'b1;
      step();
      check("t6_irq", {31'h0, irq}, 32'h0);
      check("t6_icause", {28'h0, icause}, 32'h0);
      check_reg("t6_pending", 8'h00, 32'h0);
      check_reg("t6_mask", 8'h04, 32'hF);
      rst = 1'b0;
      irq_src = '0;
      step();
      step();
      check("t6_after_irq", {31'h0, irq}, 32'h0);

      if (exp_q.size() != 0) begin
         tests_run++;
         tests_failed++;
         $error("FAIL queue_drain: observed %0d leftover grants expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
